// File: rtl/wb_port_arbiter_pkg.sv
// Shared types and widths for the writeback port arbiter.
//   DW, AW    : data / register index widths
//   wb_cand_t : one write candidate {valid, rd, data}
//   idx_w()   : pointer width for a power-of-two queue depth
package wb_port_arbiter_pkg;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_cand_t;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of lane, load-return and register-file write-port signals.
//   master : issue lanes / load unit side (drives lanes and load returns)
//   slave  : the arbiter (drives write ports, lr_ready and queue status)
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
  #(parameter int LQ_DEPTH = 4);
  logic                       l0_valid, l1_valid, lr_valid, lr_ready;
  logic [AW-1:0]              l0_rd, l1_rd, lr_rd;
  logic [DW-1:0]              l0_data, l1_data, lr_data;
  logic                       we, we2;
  logic [AW-1:0]              wr_rd1, wr_rd2;
  logic [DW-1:0]              wr_data1, wr_data2;
  logic                       lq_empty;
  logic [idx_w(LQ_DEPTH):0]   lq_count;

  modport master (
    output l0_valid, l0_rd, l0_data, l1_valid, l1_rd, l1_data,
           lr_valid, lr_rd, lr_data,
    input  lr_ready, we, wr_rd1, wr_data1, we2, wr_rd2, wr_data2, lq_empty, lq_count
  );
  modport slave (
    input  l0_valid, l0_rd, l0_data, l1_valid, l1_rd, l1_data,
           lr_valid, lr_rd, lr_data,
    output lr_ready, we, wr_rd1, wr_data1, we2, wr_rd2, wr_data2, lq_empty, lq_count
  );
endinterface

// File: rtl/wb_load_queue.sv
// Circular load-return FIFO with per-entry kill bits.
//   push/push_rd/push_data : enqueue one entry
//   pop                    : retire the head (caller guarantees hd_valid)
//   kill0/kill1            : lane writes this cycle; matching entries (including the
//                            one being pushed) are marked killed
//   hd_*                   : head entry view; hd_killed is the registered kill bit
//   full/count             : occupancy (killed entries count until popped)
module wb_load_queue
  import wb_port_arbiter_pkg::*;
  #(parameter int LQ_DEPTH = 4)
  (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [AW-1:0]            push_rd,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  input  wb_cand_t                 kill0,
  input  wb_cand_t                 kill1,
  output logic                     hd_valid,
  output logic [AW-1:0]            hd_rd,
  output logic [DW-1:0]            hd_data,
  output logic                     hd_killed,
  output logic                     full,
  output logic [idx_w(LQ_DEPTH):0] count
);
  localparam int IW = idx_w(LQ_DEPTH);

  logic [LQ_DEPTH-1:0][AW-1:0] rd_q;
  logic [LQ_DEPTH-1:0][DW-1:0] data_q;
  logic [LQ_DEPTH-1:0]         kill_q;
  logic [IW-1:0]               hd, tl;

  function automatic logic hit(input wb_cand_t k, input logic [AW-1:0] rd);
    return k.valid && (k.rd == rd);
  endfunction

  assign hd_valid  = (count != '0);
  assign hd_rd     = rd_q[hd];
  assign hd_data   = data_q[hd];
  assign hd_killed = kill_q[hd];
  assign full      = (count == (IW+1)'(LQ_DEPTH));

  // Payload needs no reset: occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tl]   <= push_rd;
      data_q[tl] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hd     <= '0;
      tl     <= '0;
      count  <= '0;
      kill_q <= '0;
    end else begin
      // Stale slots may pick up kill bits; push overwrites them.
      for (int i = 0; i < LQ_DEPTH; i++)
        if (hit(kill0, rd_q[i]) || hit(kill1, rd_q[i])) kill_q[i] <= 1'b1;
      if (push) begin
        kill_q[tl] <= hit(kill0, push_rd) || hit(kill1, push_rd);
        tl         <= tl + 1'b1;
      end
      if (pop) hd <= hd + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback arbiter: packs lane0, lane1 and the load-queue head onto the register
// file's two write ports, buffering load returns and killing stale loads.
//   clk, rst : clock, async active-low reset (write outputs forced to 0 while low)
//   bus      : lanes, load-return handshake, write ports, queue status
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
  #(parameter int LQ_DEPTH = 4)
  (
  input logic              clk,
  input logic              rst,
  wb_port_arbiter_if.slave bus
);
  wb_cand_t      c0, c1, ch, p1, p2;
  logic          hd_valid, hd_killed, head_kill, pop, push, full;
  logic [AW-1:0] hd_rd;
  logic [DW-1:0] hd_data;

  always_comb begin
    c0.valid = bus.l0_valid && (bus.l0_rd != '0);
    c0.rd    = bus.l0_rd;
    c0.data  = bus.l0_data;
    c1.valid = bus.l1_valid && (bus.l1_rd != '0);
    c1.rd    = bus.l1_rd;
    c1.data  = bus.l1_data;
    if (c0.valid && c1.valid && (c0.rd == c1.rd)) c0.valid = 1'b0;

    // A head matching a lane written this cycle is already stale: retire it
    // without a port so the older load can never land after the lane value.
    head_kill = hd_killed || (c0.valid && c0.rd == hd_rd) || (c1.valid && c1.rd == hd_rd);
    ch.valid  = hd_valid && !head_kill;
    ch.rd     = hd_rd;
    ch.data   = hd_data;

    p1 = c0.valid ? c0 : (c1.valid ? c1 : ch);
    p2 = '0;
    if (c0.valid && c1.valid)      p2 = c1;
    else if (c0.valid || c1.valid) p2 = ch;

    pop = hd_valid && (head_kill || !(c0.valid && c1.valid));
  end

  assign bus.lr_ready = rst && !full;
  assign push         = bus.lr_valid && bus.lr_ready && (bus.lr_rd != '0);

  wb_load_queue #(.LQ_DEPTH(LQ_DEPTH)) u_lq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (bus.lr_rd),
    .push_data (bus.lr_data),
    .pop       (pop),
    .kill0     (c0),
    .kill1     (c1),
    .hd_valid  (hd_valid),
    .hd_rd     (hd_rd),
    .hd_data   (hd_data),
    .hd_killed (hd_killed),
    .full      (full),
    .count     (bus.lq_count)
  );

  assign bus.lq_empty = (bus.lq_count == '0);

  // Reset gates the combinational lane paths so the ports are quiet immediately.
  assign bus.we       = rst && p1.valid;
  assign bus.wr_rd1   = bus.we  ? p1.rd   : '0;
  assign bus.wr_data1 = bus.we  ? p1.data : '0;
  assign bus.we2      = rst && p2.valid;
  assign bus.wr_rd2   = bus.we2 ? p2.rd   : '0;
  assign bus.wr_data2 = bus.we2 ? p2.data : '0;
endmodule
